// File: rtl/multicycle_control_pkg.sv
// ============================================================================
// Module : multicycle_control_pkg
// Brief  : Shared codes for the multi-cycle RV core sequencer: opcodes, state
//          encodings, ALUOp codes and ALU operand-B select codes.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package multicycle_control_pkg;

  // Major opcodes (IR[6:0]) understood by the sequencer
  localparam logic [6:0] OPC_R      = 7'b0110011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  // ALUOp codes handed to alu_control
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // ALU operand-B selects
  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;

  // Sequencer state codes; the numeric values are visible on the debug port
  typedef enum logic [3:0] {
    ST_FETCH  = 4'd0,
    ST_DECODE = 4'd1,
    ST_EXEC_R = 4'd2,
    ST_WB_R   = 4'd3,
    ST_ADDR   = 4'd4,
    ST_MEM_RD = 4'd5,
    ST_WB_MEM = 4'd6,
    ST_MEM_WR = 4'd7,
    ST_BRANCH = 4'd8,
    ST_HALT   = 4'd15
  } state_t;

  // True for the opcodes the core can execute
  function automatic logic opc_legal(input logic [6:0] opc);
    return (opc == OPC_R) || (opc == OPC_LOAD) ||
           (opc == OPC_STORE) || (opc == OPC_BRANCH);
  endfunction

endpackage

`default_nettype wire

// File: rtl/multicycle_control_retire_counter.sv
// ============================================================================
// Module : multicycle_control_retire_counter
// Brief  : Retired-instruction counter; increments on inc, wraps modulo
//          2^WIDTH, cleared asynchronously by reset_n.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module multicycle_control_retire_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] r_count;

  // Count one per retired instruction; natural overflow gives the wrap
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_count <= '0;
    end else if (inc) begin
      r_count <= r_count + {{(WIDTH-1){1'b0}}, 1'b1};
    end
  end

  assign count = r_count;

endmodule

`default_nettype wire

// File: rtl/multicycle_control.sv
// ============================================================================
// Module : multicycle_control
// Brief  : Multi-cycle sequencer for the sequential RV core. Walks each
//          instruction through fetch/decode/execute/memory/writeback, driving
//          datapath selects, ALUOp and the single memory port handshake.
//          Counts retired instructions and halts on an unsupported opcode.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module multicycle_control
  import multicycle_control_pkg::*;
#(
  parameter int RETIRE_W = 32
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [6:0]          opcode,
  input  logic                zero,
  input  logic                mem_ready,
  output logic                mem_req,
  output logic                mem_we,
  output logic                iord,
  output logic                ir_write,
  output logic                pc_write,
  output logic                pc_src,
  output logic                alu_src_a,
  output logic [1:0]          alu_src_b,
  output logic [1:0]          alu_op,
  output logic                reg_write,
  output logic                mem_to_reg,
  output logic [3:0]          state,
  output logic                halted,
  output logic [RETIRE_W-1:0] instr_retired
);

  state_t r_state;
  logic   r_halted;
  logic   w_retire;

  // State register and next-state selection; halted latches on the way into HALT
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= ST_FETCH;
      r_halted <= 1'b0;
    end else begin
      case (r_state)
        ST_FETCH:  if (mem_ready) r_state <= ST_DECODE;
        ST_DECODE: begin
          if (opcode == OPC_R) begin
            r_state <= ST_EXEC_R;
          end else if ((opcode == OPC_LOAD) || (opcode == OPC_STORE)) begin
            r_state <= ST_ADDR;
          end else if (opcode == OPC_BRANCH) begin
            r_state <= ST_BRANCH;
          end else begin
            r_state  <= ST_HALT;
            r_halted <= 1'b1;
          end
        end
        ST_EXEC_R: r_state <= ST_WB_R;
        ST_WB_R:   r_state <= ST_FETCH;
        ST_ADDR:   r_state <= (opcode == OPC_LOAD) ? ST_MEM_RD : ST_MEM_WR;
        ST_MEM_RD: if (mem_ready) r_state <= ST_WB_MEM;
        ST_WB_MEM: r_state <= ST_FETCH;
        ST_MEM_WR: if (mem_ready) r_state <= ST_FETCH;
        ST_BRANCH: r_state <= ST_FETCH;
        ST_HALT:   r_state <= ST_HALT;
        default: begin
          r_state  <= ST_HALT;
          r_halted <= 1'b1;
        end
      endcase
    end
  end

  // An instruction retires on the edge that leaves its final state
  always_comb begin
    w_retire = 1'b0;
    case (r_state)
      ST_WB_R, ST_WB_MEM, ST_BRANCH: w_retire = 1'b1;
      ST_MEM_WR:                     w_retire = mem_ready;
      default:                       w_retire = 1'b0;
    endcase
  end

  // Control decode from state; everything is forced low while reset is held
  always_comb begin
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    iord       = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_src     = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = SRCB_RS2;
    alu_op     = ALUOP_ADD;
    reg_write  = 1'b0;
    mem_to_reg = 1'b0;
    case (r_state)
      ST_FETCH: begin
        mem_req   = 1'b1;
        alu_src_b = SRCB_FOUR;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      ST_DECODE: begin
        alu_src_b = SRCB_IMM;
      end
      ST_EXEC_R: begin
        alu_src_a = 1'b1;
        alu_op    = ALUOP_FUNCT;
      end
      ST_WB_R: begin
        reg_write = 1'b1;
      end
      ST_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
      end
      ST_MEM_RD: begin
        mem_req = 1'b1;
        iord    = 1'b1;
      end
      ST_WB_MEM: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      ST_MEM_WR: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
        iord    = 1'b1;
      end
      ST_BRANCH: begin
        alu_src_a = 1'b1;
        alu_op    = ALUOP_SUB;
        pc_src    = 1'b1;
        pc_write  = zero;
      end
      default: ;
    endcase
    if (!reset_n) begin
      mem_req    = 1'b0;
      mem_we     = 1'b0;
      iord       = 1'b0;
      ir_write   = 1'b0;
      pc_write   = 1'b0;
      pc_src     = 1'b0;
      alu_src_a  = 1'b0;
      alu_src_b  = 2'b00;
      alu_op     = 2'b00;
      reg_write  = 1'b0;
      mem_to_reg = 1'b0;
    end
  end

  multicycle_control_retire_counter #(
    .WIDTH (RETIRE_W)
  ) u_retire_counter (
    .clk     (clk),
    .reset_n (reset_n),
    .inc     (w_retire),
    .count   (instr_retired)
  );

  assign state  = r_state;
  assign halted = r_halted;

endmodule

`default_nettype wire

// File: tb/tb_multicycle_control.sv
// ============================================================================
// Module : tb_multicycle_control
// Brief  : Directed bench for multicycle_control. A 32-bit-counter instance
//          and a 4-bit-counter instance share the same stimulus.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_multicycle_control;

  // {mem_req, mem_we, iord, ir_write, pc_write, pc_src, alu_src_a,
  //  alu_src_b[1:0], alu_op[1:0], reg_write, mem_to_reg}
  localparam logic [12:0] C_ZERO   = 13'b0000000_00_00_00;
  localparam logic [12:0] C_F_WAIT = 13'b1000000_01_00_00;
  localparam logic [12:0] C_F_RDY  = 13'b1001100_01_00_00;
  localparam logic [12:0] C_DEC    = 13'b0000000_10_00_00;
  localparam logic [12:0] C_EXR    = 13'b0000001_00_10_00;
  localparam logic [12:0] C_WBR    = 13'b0000000_00_00_10;
  localparam logic [12:0] C_ADDR   = 13'b0000001_10_00_00;
  localparam logic [12:0] C_MRD    = 13'b1010000_00_00_00;
  localparam logic [12:0] C_WBM    = 13'b0000000_00_00_11;
  localparam logic [12:0] C_MWR    = 13'b1110000_00_00_00;
  localparam logic [12:0] C_BR1    = 13'b0000111_00_01_00;
  localparam logic [12:0] C_BR0    = 13'b0000011_00_01_00;

  localparam logic [6:0] C_OPC_R   = 7'b0110011;
  localparam logic [6:0] C_OPC_LD  = 7'b0000011;
  localparam logic [6:0] C_OPC_ST  = 7'b0100011;
  localparam logic [6:0] C_OPC_BR  = 7'b1100011;
  localparam logic [6:0] C_OPC_BAD = 7'b1111111;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [6:0]  opcode;
  logic        zero;
  logic        mem_ready;

  logic        mem_req, mem_we, iord, ir_write, pc_write, pc_src, alu_src_a;
  logic [1:0]  alu_src_b, alu_op;
  logic        reg_write, mem_to_reg, halted;
  logic [3:0]  state;
  logic [31:0] instr_retired;

  logic        mem_req_4, mem_we_4, iord_4, ir_write_4, pc_write_4, pc_src_4, alu_src_a_4;
  logic [1:0]  alu_src_b_4, alu_op_4;
  logic        reg_write_4, mem_to_reg_4, halted_4;
  logic [3:0]  state_4;
  logic [3:0]  instr_retired_4;

  logic [12:0] w_ctl;

  int n_total = 0;
  int n_pass  = 0;
  int exp_ret = 0;

  always #5 clk = ~clk;

  assign w_ctl = {mem_req, mem_we, iord, ir_write, pc_write, pc_src, alu_src_a,
                  alu_src_b, alu_op, reg_write, mem_to_reg};

  multicycle_control #(.RETIRE_W(32)) dut (
    .clk(clk), .reset_n(reset_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_we(mem_we), .iord(iord), .ir_write(ir_write),
    .pc_write(pc_write), .pc_src(pc_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_op(alu_op), .reg_write(reg_write), .mem_to_reg(mem_to_reg), .state(state),
    .halted(halted), .instr_retired(instr_retired)
  );

  multicycle_control #(.RETIRE_W(4)) dut4 (
    .clk(clk), .reset_n(reset_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .mem_req(mem_req_4), .mem_we(mem_we_4), .iord(iord_4), .ir_write(ir_write_4),
    .pc_write(pc_write_4), .pc_src(pc_src_4), .alu_src_a(alu_src_a_4), .alu_src_b(alu_src_b_4),
    .alu_op(alu_op_4), .reg_write(reg_write_4), .mem_to_reg(mem_to_reg_4), .state(state_4),
    .halted(halted_4), .instr_retired(instr_retired_4)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end else begin
      n_pass++;
    end
  endtask

  // One clock cycle: apply inputs at posedge+1, sample at posedge+4, end at next posedge+1
  task automatic cyc(input string tag, input logic [3:0] exp_st, input logic [12:0] exp_ctl,
                     input logic rdy, input logic z);
    mem_ready = rdy;
    zero      = z;
    #3;
    check({tag, "_st"}, {28'd0, state}, {28'd0, exp_st});
    check({tag, "_ctl"}, {19'd0, w_ctl}, {19'd0, exp_ctl});
    @(posedge clk);
    #1;
  endtask

  task automatic check_ret(input string tag);
    check({tag, "_ret"}, instr_retired, exp_ret);
    check({tag, "_ret4"}, {28'd0, instr_retired_4}, exp_ret % 16);
  endtask

  task automatic run_r(input string tag);
    opcode = C_OPC_R;
    cyc({tag, "_f"}, 4'd0, C_F_RDY, 1'b1, 1'b0);
    cyc({tag, "_d"}, 4'd1, C_DEC,   1'b1, 1'b0);
    cyc({tag, "_e"}, 4'd2, C_EXR,   1'b1, 1'b0);
    cyc({tag, "_w"}, 4'd3, C_WBR,   1'b1, 1'b0);
    exp_ret++;
    check({tag, "_end"}, {28'd0, state}, 32'd0);
    check_ret(tag);
  endtask

  initial begin
    reset_n   = 1'b0;
    opcode    = 7'd0;
    zero      = 1'b0;
    mem_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    #3;
    check("rst_st", {28'd0, state}, 32'd0);
    check("rst_halt", {31'd0, halted}, 32'd0);
    check_ret("rst");
    @(posedge clk);
    #1;

    // R-type with ready memory
    run_r("radd");

    // LOAD with 2 fetch waits and 3 read waits: 10 cycles
    opcode = C_OPC_LD;
    cyc("ld_fw0", 4'd0, C_F_WAIT, 1'b0, 1'b0);
    cyc("ld_fw1", 4'd0, C_F_WAIT, 1'b0, 1'b0);
    cyc("ld_f",   4'd0, C_F_RDY,  1'b1, 1'b0);
    cyc("ld_d",   4'd1, C_DEC,    1'b1, 1'b0);
    cyc("ld_a",   4'd4, C_ADDR,   1'b1, 1'b0);
    for (int i = 0; i < 3; i++) cyc("ld_mw", 4'd5, C_MRD, 1'b0, 1'b0);
    cyc("ld_m",   4'd5, C_MRD,    1'b1, 1'b0);
    cyc("ld_wb",  4'd6, C_WBM,    1'b1, 1'b0);
    exp_ret++;
    check("ld_end", {28'd0, state}, 32'd0);
    check_ret("ld");

    // Reset asserted mid-MEM_RD for 3 cycles
    cyc("rs_f", 4'd0, C_F_RDY, 1'b1, 1'b0);
    cyc("rs_d", 4'd1, C_DEC,   1'b1, 1'b0);
    cyc("rs_a", 4'd4, C_ADDR,  1'b1, 1'b0);
    cyc("rs_m", 4'd5, C_MRD,   1'b0, 1'b0);
    reset_n = 1'b0;
    exp_ret = 0;
    for (int i = 0; i < 3; i++) begin
      cyc("rs_hold", 4'd0, C_ZERO, 1'b1, 1'b0);
      check("rs_halt", {31'd0, halted}, 32'd0);
      check_ret("rs_hold");
    end
    reset_n = 1'b1;

    // STORE: 4 cycles
    opcode = C_OPC_ST;
    cyc("st_f", 4'd0, C_F_RDY, 1'b1, 1'b0);
    cyc("st_d", 4'd1, C_DEC,   1'b1, 1'b0);
    cyc("st_a", 4'd4, C_ADDR,  1'b1, 1'b0);
    cyc("st_w", 4'd7, C_MWR,   1'b1, 1'b0);
    exp_ret++;
    check("st_end", {28'd0, state}, 32'd0);
    check_ret("st");

    // BRANCH taken then not taken
    opcode = C_OPC_BR;
    cyc("bt_f", 4'd0, C_F_RDY, 1'b1, 1'b1);
    cyc("bt_d", 4'd1, C_DEC,   1'b1, 1'b1);
    cyc("bt_b", 4'd8, C_BR1,   1'b1, 1'b1);
    exp_ret++;
    check_ret("bt");
    cyc("bn_f", 4'd0, C_F_RDY, 1'b1, 1'b0);
    cyc("bn_d", 4'd1, C_DEC,   1'b1, 1'b0);
    cyc("bn_b", 4'd8, C_BR0,   1'b1, 1'b0);
    exp_ret++;
    check("bn_end", {28'd0, state}, 32'd0);
    check_ret("bn");

    // Fill up to 16 retirements so the 4-bit counter wraps to 0
    while (exp_ret < 16) run_r("wrap");
    check("wrap32", instr_retired, 32'd16);
    check("wrap4", {28'd0, instr_retired_4}, 32'd0);

    // Illegal opcode halts without retiring
    opcode = C_OPC_BAD;
    cyc("h_f", 4'd0, C_F_RDY, 1'b1, 1'b0);
    cyc("h_d", 4'd1, C_DEC,   1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cyc("h_halt", 4'd15, C_ZERO, 1'b1, 1'b1);
      check("h_flag", {31'd0, halted}, 32'd1);
      check("h_flag4", {31'd0, halted_4}, 32'd1);
      check_ret("h");
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
